// File: rtl/round_robin_arbiter_with_hold_if.sv
// Requester/arbiter bundle for round_robin_arbiter_with_hold.
//   requests  : level request per requester (driven by the requester side)
//   grants    : one-hot grant or zero (driven by the arbiter)
//   grant_vld : |grants
//   grant_id  : index of the granted requester, 0 when nothing is granted
interface round_robin_arbiter_with_hold_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  requests;
    logic [N-1:0]  grants;
    logic          grant_vld;
    logic [IW-1:0] grant_id;

    modport master (
        output requests,
        input  grants,
        input  grant_vld,
        input  grant_id
    );

    modport slave (
        input  requests,
        output grants,
        output grant_vld,
        output grant_id
    );
endinterface

// File: rtl/round_robin_arbiter_with_hold.sv
// N-way round-robin arbiter with multi-cycle ownership.
// A granted requester keeps its grant while it holds its request; after
// MAX_HOLD owned cycles the grant rotates if anyone else is waiting
// (MAX_HOLD = 0 disables the limit).
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : slave side of round_robin_arbiter_with_hold_if
//          (requests in; grants, grant_vld, grant_id registered out)
module round_robin_arbiter_with_hold #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic clk,
    input logic rst,
    round_robin_arbiter_with_hold_if.slave bus
);
    localparam int unsigned IW        = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grants_q, grants_d;
    logic          grant_vld_q, grant_vld_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  cand;
    logic [IW-1:0] sel;
    logic          owner_req;
    logic          hold_last;
    logic          take_new;
    logic          go_idle;

    // First set bit of cand scanning ptr, ptr+1, ... modulo N.
    function automatic logic [IW-1:0] rr_first(input logic [N-1:0]  c,
                                               input logic [IW-1:0] ptr);
        logic [IW-1:0] s;
        logic          found;
        s     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % N;
            if (!found && c[IW'(idx)]) begin
                found = 1'b1;
                s     = IW'(idx);
            end
        end
        return s;
    endfunction

    // Next-state / next-output logic.
    always_comb begin
        state_d     = state_q;
        grants_d    = grants_q;
        grant_vld_d = grant_vld_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        take_new    = 1'b0;
        go_idle     = 1'b0;

        // Candidates exclude the current owner; in IDLE grants_q is zero so
        // this is simply every requester.
        cand      = bus.requests & ~grants_q;
        sel       = rr_first(cand, ptr_q);
        owner_req = |(bus.requests & grants_q);
        hold_last = (MAX_HOLD != 0) && (hold_q == HW'(HOLD_LAST));

        case (state_q)
            IDLE: begin
                take_new = |cand;
            end
            OWNED: begin
                if (!owner_req) begin
                    take_new = |cand;
                    go_idle  = ~|cand;
                end else if (hold_last && (|cand)) begin
                    take_new = 1'b1;
                end else if (hold_q != HW'(HOLD_LAST)) begin
                    // Saturates at the last slot so a late arrival rotates next cycle.
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (take_new) begin
            state_d     = OWNED;
            grants_d    = N'(1) << sel;
            grant_vld_d = 1'b1;
            grant_id_d  = sel;
            ptr_d       = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
            hold_d      = '0;
        end else if (go_idle) begin
            state_d     = IDLE;
            grants_d    = '0;
            grant_vld_d = 1'b0;
            grant_id_d  = '0;
            hold_d      = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grants_q    <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            grants_q    <= grants_d;
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.grants    = grants_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_round_robin_arbiter_with_hold.sv
module tb_round_robin_arbiter_with_hold;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

    logic clk;
    logic rst;

    round_robin_arbiter_with_hold_if #(.N(N)) bus ();

    round_robin_arbiter_with_hold #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: owner index (-1 = none), next-priority pointer,
    // and number of cycles the current owner has held the grant.
    int           m_owner;
    int           m_ptr;
    int           m_held;
    logic [N-1:0] m_grants;
    logic [N-1:0] prev_req;

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr, input int excl);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (req[k] && k != excl) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 0;
        m_held   = 0;
        m_grants = '0;
    endtask

    task automatic model_step(input logic [N-1:0] req);
        int  k;
        bit  keep;
        keep = 1'b0;
        if (m_owner >= 0 && req[m_owner]) begin
            keep = (rr_pick(req, m_ptr, m_owner) < 0) || (MAX_HOLD == 0) || (m_held < MAX_HOLD);
        end
        if (keep) begin
            m_held++;
        end else begin
            k = rr_pick(req, m_ptr, m_owner);
            if (k < 0) begin
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_owner = k;
                m_ptr   = (k + 1) % N;
                m_held  = 1;
            end
        end
        m_grants = '0;
        if (m_owner >= 0) m_grants[m_owner] = 1'b1;
    endtask

    // Apply one request vector across one rising edge; outputs are then stable.
    task automatic cycle(input logic [N-1:0] req);
        bus.requests = req;
        prev_req     = req;
        model_step(req);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.requests = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (bus.grants !== 4'b0000 || bus.grant_vld !== 1'b0 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: grants=%b vld=%b id=%0d, required 0000/0/0",
                     bus.grants, bus.grant_vld, bus.grant_id);
        end
        cycle(4'b0001);
        vectors++;
        if (bus.grants !== 4'b0001 || bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL first_grant: grants=%b vld=%b id=%0d, required 0001/1/0",
                     bus.grants, bus.grant_vld, bus.grant_id);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            cycle(4'b1111);
            exp = 4'b0001 << ((c / MAX_HOLD) % N);
            vectors++;
            if (bus.grants !== exp || bus.grant_vld !== 1'b1) begin
                miscompares++;
                $display("FAIL rotation c=%0d: grants=%b vld=%b, required %b/1",
                         c, bus.grants, bus.grant_vld, exp);
            end
        end
    endtask

    task automatic test_release();
        apply_reset();
        cycle(4'b0100);
        cycle(4'b0101);
        vectors++;
        if (bus.grants !== 4'b0100) begin
            miscompares++;
            $display("FAIL release_hold: grants=%b, required 0100", bus.grants);
        end
        cycle(4'b0001);
        vectors++;
        if (bus.grants !== 4'b0001 || bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL release_handoff: grants=%b vld=%b id=%0d, required 0001/1/0",
                     bus.grants, bus.grant_vld, bus.grant_id);
        end
        cycle(4'b0000);
        vectors++;
        if (bus.grants !== 4'b0000 || bus.grant_vld !== 1'b0 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL release_idle: grants=%b vld=%b id=%0d, required 0000/0/0",
                     bus.grants, bus.grant_vld, bus.grant_id);
        end
    endtask

    task automatic test_sole_hold();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            cycle(4'b0010);
            vectors++;
            if (bus.grants !== 4'b0010 || bus.grant_id !== 2'd1) begin
                miscompares++;
                $display("FAIL sole_hold c=%0d: grants=%b id=%0d, required 0010/1",
                         c, bus.grants, bus.grant_id);
            end
        end
        cycle(4'b1010);
        vectors++;
        if (bus.grants !== 4'b1000 || bus.grant_id !== 2'd3) begin
            miscompares++;
            $display("FAIL sole_late_arrival: grants=%b id=%0d, required 1000/3",
                     bus.grants, bus.grant_id);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        cycle(4'b0100);
        cycle(4'b0100);
        rst          = 1'b1;
        bus.requests = 4'b0100;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.grants !== 4'b0000 || bus.grant_vld !== 1'b0 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset: grants=%b vld=%b id=%0d, required 0000/0/0",
                     bus.grants, bus.grant_vld, bus.grant_id);
        end
        rst = 1'b0;
        model_reset();
        cycle(4'b1111);
        vectors++;
        if (bus.grants !== 4'b0001) begin
            miscompares++;
            $display("FAIL pointer_reset: grants=%b, required 0001", bus.grants);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        int           waitc [N];
        int           exp_id;
        apply_reset();
        req = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                req = N'($urandom);
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (req[i]) req[i] = ($urandom_range(0, 7) != 0);
                    else        req[i] = ($urandom_range(0, 3) == 0);
                end
            end
            cycle(req);
            exp_id = (m_owner < 0) ? 0 : m_owner;

            vectors++;
            if (bus.grants !== m_grants || bus.grant_vld !== (m_owner >= 0) ||
                bus.grant_id !== 2'(exp_id)) begin
                miscompares++;
                $display("FAIL random_model c=%0d req=%b: grants=%b vld=%b id=%0d, required %b/%0d/%0d",
                         c, req, bus.grants, bus.grant_vld, bus.grant_id,
                         m_grants, (m_owner >= 0), exp_id);
            end
            vectors++;
            if ($onehot0(bus.grants) !== 1'b1) begin
                miscompares++;
                $display("FAIL random_onehot c=%0d: grants=%b, required one-hot or zero", c, bus.grants);
            end
            vectors++;
            if ((bus.grants & ~prev_req) !== '0) begin
                miscompares++;
                $display("FAIL random_unrequested c=%0d: grants=%b req=%b, required grants within req",
                         c, bus.grants, prev_req);
            end
            for (int i = 0; i < N; i++) begin
                if (prev_req[i] && !bus.grants[i]) waitc[i]++;
                else                               waitc[i] = 0;
                if (prev_req[i]) begin
                    vectors++;
                    if (waitc[i] >= BOUND) begin
                        miscompares++;
                        $display("FAIL random_fairness c=%0d req%0d: waited %0d cycles, required < %0d",
                                 c, i, waitc[i], BOUND);
                    end
                end
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.requests = '0;
        prev_req     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_release();
        test_sole_hold();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
